// File: rtl/redstone_pkg.sv
// Shared definitions for the redstone digit-serial ALU.
//   ALU_* op codes, redstone_t (one 4-bit redstone digit), sequencer states.
package redstone_pkg;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MAX = 2'b10;
  localparam logic [1:0] ALU_DIF = 2'b11;

  typedef logic [3:0] redstone_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    CAPTURE = 3'd2,
    FINISH  = 3'd3,
    RESP    = 3'd4
  } seq_state_t;
endpackage

// File: rtl/redstone_alu_seq_if.sv
// Request/response bus of the redstone ALU sequencer.
//   req_*: valid/ready request (op, a, b); rsp_*: valid/ready response (result, carry).
//   master = requester (CPU control path), slave = sequencer.
interface redstone_alu_seq_if #(parameter int WIDTH = 12);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry
  );
endinterface

// File: rtl/redstone_digit_alu.sv
// Combinational single-digit redstone ALU.
//   i_a_d, i_b_d : operand digits       i_cin : carry/borrow in
//   i_op         : ALU_ADD adds, every other op subtracts (a - b - cin)
//   o_out, o_cout: digit result and carry/borrow out
//   o_a_gt/o_b_gt: digit magnitude compare (a>b / b>a)
module redstone_digit_alu
  import redstone_pkg::*;
(
  input  redstone_t  i_a_d,
  input  redstone_t  i_b_d,
  input  logic       i_cin,
  input  logic [1:0] i_op,
  output redstone_t  o_out,
  output logic       o_cout,
  output logic       o_a_gt,
  output logic       o_b_gt
);
  logic [4:0] w_sum;
  logic [4:0] w_dif;

  // 5-bit wrap of a-b-cin: bit 4 set exactly when a < b+cin
  assign w_sum = {1'b0, i_a_d} + {1'b0, i_b_d} + {4'b0, i_cin};
  assign w_dif = {1'b0, i_a_d} - {1'b0, i_b_d} - {4'b0, i_cin};

  always_comb begin
    o_out  = w_dif[3:0];
    o_cout = w_dif[4];
    if (i_op == ALU_ADD) begin
      o_out  = w_sum[3:0];
      o_cout = w_sum[4];
    end
  end

  assign o_a_gt = (i_a_d > i_b_d);
  assign o_b_gt = (i_b_d > i_a_d);
endmodule

// File: rtl/redstone_alu_seq.sv
// Digit-serial sequencer around one shared redstone_digit_alu.
//   i_clk, i_reset (sync, active high)
//   bus (slave): request op/a/b in, result/carry out, both valid/ready.
// Operands walk LSB digit first; each digit is held SETTLE cycles on the
// digit ALU, then captured. DIF runs a second pass with swapped operands
// when the first pass borrows.
module redstone_alu_seq
  import redstone_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int SETTLE = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  redstone_alu_seq_if.slave bus
);
  localparam int NDIG = WIDTH / 4;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("redstone_alu_seq: WIDTH must be a positive multiple of 4");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("redstone_alu_seq: SETTLE must be >= 1");
  end

  seq_state_t             r_state;
  logic [1:0]             r_op;
  redstone_t [NDIG-1:0]   r_a, r_b, r_res;
  logic                   r_carry, r_gt, r_pass;
  logic [IDXW-1:0]        r_idx;
  logic [CNTW-1:0]        r_cnt;
  logic                   r_rsp_valid;
  logic [WIDTH-1:0]       r_rsp_result;
  logic                   r_rsp_carry;

  redstone_t w_out;
  logic      w_cout, w_a_gt, w_b_gt;

  redstone_digit_alu u_dig (
    .i_a_d  (r_a[r_idx]),
    .i_b_d  (r_b[r_idx]),
    .i_cin  (r_carry),
    .i_op   (r_op),
    .o_out  (w_out),
    .o_cout (w_cout),
    .o_a_gt (w_a_gt),
    .o_b_gt (w_b_gt)
  );

  assign bus.req_ready  = (r_state == IDLE) && !i_reset;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_carry  = r_rsp_carry;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_op         <= ALU_ADD;
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
      r_carry      <= 1'b0;
      r_gt         <= 1'b0;
      r_pass       <= 1'b0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_op    <= bus.req_op;
          r_a     <= bus.req_a;
          r_b     <= bus.req_b;
          r_carry <= 1'b0;
          r_gt    <= 1'b0;
          r_pass  <= 1'b0;
          r_idx   <= '0;
          r_cnt   <= '0;
          r_state <= DRIVE;
        end
        DRIVE: begin
          if (r_cnt == CNTW'(SETTLE - 1)) begin
            r_cnt   <= '0;
            r_state <= CAPTURE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        CAPTURE: begin
          r_res[r_idx] <= w_out;
          r_carry      <= w_cout;
          // higher digits are seen later, so they override the compare
          if (w_b_gt)      r_gt <= 1'b1;
          else if (w_a_gt) r_gt <= 1'b0;
          if (r_idx == IDXW'(NDIG - 1)) begin
            r_state <= FINISH;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= DRIVE;
          end
        end
        FINISH: begin
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
          case (r_op)
            ALU_MAX: begin
              r_rsp_result <= r_gt ? r_b : r_a;
              r_rsp_carry  <= r_gt;
            end
            ALU_DIF: begin
              if (!r_pass && r_carry) begin
                // a<b: rerun as b-a
                r_a         <= r_b;
                r_b         <= r_a;
                r_pass      <= 1'b1;
                r_carry     <= 1'b0;
                r_idx       <= '0;
                r_cnt       <= '0;
                r_state     <= DRIVE;
                r_rsp_valid <= 1'b0;
              end else begin
                r_rsp_result <= r_res;
                r_rsp_carry  <= r_pass;
              end
            end
            default: begin
              r_rsp_result <= r_res;
              r_rsp_carry  <= r_carry;
            end
          endcase
        end
        RESP: if (bus.rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_redstone_alu_seq.sv
module tb_redstone_alu_seq;
  import redstone_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  redstone_alu_seq_if #(.WIDTH(12)) bus ();

  redstone_alu_seq #(.WIDTH(12), .SETTLE(2)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] r;
    logic        c;
    int          lat;
    int          acc;
    int          id;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input int id, input logic [1:0] op, input logic [11:0] a,
                       input logic [11:0] b, input logic [11:0] er, input logic ec,
                       input int lat, input bit push);
    int n = 0;
    exp_t e;
    while (!bus.req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.req_ready) chk($sformatf("req%0d_ready_timeout", id), 0, 1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (push) begin
      e.r = er; e.c = ec; e.lat = lat; e.acc = cyc; e.id = id;
      sbq.push_back(e);
    end
  endtask

  // Monitor: compare once per presented response.
  initial begin
    bit   seen = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!bus.rsp_valid) seen = 0;
      else if (!seen) begin
        seen = 1;
        if (sbq.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          e = sbq.pop_front();
          chk($sformatf("rsp%0d_result", e.id), 32'(bus.rsp_result), 32'(e.r));
          chk($sformatf("rsp%0d_carry", e.id), 32'(bus.rsp_carry), 32'(e.c));
          chk($sformatf("rsp%0d_latency", e.id), 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req_valid = 1'b0;
    bus.req_op    = ALU_ADD;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_result", 32'(bus.rsp_result), 0);
    chk("rst_rsp_carry", 32'(bus.rsp_carry), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_req_ready", 32'(bus.req_ready), 1);

    // directed vectors
    issue(1,  ALU_ADD, 12'h0FF, 12'h001, 12'h100, 1'b0, 10, 1);
    issue(2,  ALU_ADD, 12'hFFF, 12'h001, 12'h000, 1'b1, 10, 1);
    issue(3,  ALU_SUB, 12'h001, 12'h002, 12'hFFF, 1'b1, 10, 1);
    issue(4,  ALU_SUB, 12'h100, 12'h001, 12'h0FF, 1'b0, 10, 1);
    issue(5,  ALU_MAX, 12'h2A0, 12'h1FF, 12'h2A0, 1'b0, 10, 1);
    issue(6,  ALU_MAX, 12'h0F1, 12'h100, 12'h100, 1'b1, 10, 1);
    issue(7,  ALU_MAX, 12'h555, 12'h555, 12'h555, 1'b0, 10, 1);
    issue(8,  ALU_DIF, 12'h010, 12'h003, 12'h00D, 1'b0, 10, 1);
    issue(9,  ALU_DIF, 12'h003, 12'h010, 12'h00D, 1'b1, 20, 1);
    issue(10, ALU_DIF, 12'h444, 12'h444, 12'h000, 1'b0, 10, 1);
    issue(11, ALU_ADD, 12'hABC, 12'h123, 12'hBDF, 1'b0, 10, 1);

    // backpressure
    n = 0;
    while (!bus.req_ready && n < 100) begin @(posedge clk); #1; n++; end
    bus.rsp_ready = 1'b0;
    issue(12, ALU_SUB, 12'h234, 12'h345, 12'hEEF, 1'b1, 10, 1);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_rsp_valid_seen", 32'(bus.rsp_valid), 1);
    bus.req_valid = 1'b1;
    bus.req_op    = ALU_ADD;
    bus.req_a     = 12'h001;
    bus.req_b     = 12'h001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", i), 32'(bus.rsp_valid), 1);
      chk($sformatf("bp%0d_result", i), 32'(bus.rsp_result), 32'h0EEF);
      chk($sformatf("bp%0d_carry", i), 32'(bus.rsp_carry), 1);
      chk($sformatf("bp%0d_req_ready", i), 32'(bus.req_ready), 0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(bus.rsp_valid), 0);
    chk("bp_release_req_ready", 32'(bus.req_ready), 1);

    // reset during DRIVE of digit 1
    issue(13, ALU_ADD, 12'h777, 12'h111, 12'h888, 1'b0, 10, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_reset_req_ready", 32'(bus.req_ready), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("abort_req_ready", 32'(bus.req_ready), 1);
    issue(14, ALU_ADD, 12'h123, 12'h321, 12'h444, 1'b0, 10, 1);

    // drain
    n = 0;
    while ((sbq.size() != 0 || !bus.req_ready) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_queue_empty", 32'(sbq.size()), 0);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
